// File: rtl/wb_trace_fifo_if.sv
// Writeback capture and trace drain signals for wb_trace_fifo.
// master drives writebacks and trace_ready; slave is the FIFO.
interface wb_trace_fifo_if #(
  parameter int unsigned SeqW = 16
) ();
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [63:0]     wb_data;
  logic            trace_valid;
  logic            trace_ready;
  logic [4:0]      trace_rd;
  logic [63:0]     trace_data;
  logic [SeqW-1:0] trace_seq;

  modport master (
    output wb_valid, wb_rd, wb_data, trace_ready,
    input  trace_valid, trace_rd, trace_data, trace_seq
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data, trace_ready,
    output trace_valid, trace_rd, trace_data, trace_seq
  );
endinterface

// File: rtl/wb_trace_fifo.sv
// First-word-fall-through FIFO recording register-file writebacks (rd, data, sequence number)
// for in-order retirement checking; drops and flags writes that arrive while full.
module wb_trace_fifo #(
  parameter int unsigned Depth    = 8,
  parameter int unsigned SeqW     = 16,
  parameter bit          FilterX0 = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  wb_trace_fifo_if.slave        bus,
  output logic [$clog2(Depth):0] count_o,
  output logic                  full_o,
  output logic                  overflow_o,
  output logic [15:0]           drop_count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  logic [4:0]      rd_mem_q   [Depth];
  logic [63:0]     data_mem_q [Depth];
  logic [SeqW-1:0] seq_mem_q  [Depth];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [SeqW-1:0] seq_q, seq_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;

  logic push_req, push, pop, drop, empty, full;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == FullCnt);
    push_req = bus.wb_valid && (!FilterX0 || (bus.wb_rd != 5'd0));
    pop      = !empty && bus.trace_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push     = push_req && (!full || pop);
    drop     = push_req && full && !pop;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    seq_d      = seq_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Dropped writes still consume a sequence number so gaps expose them.
    if (push_req) seq_d = seq_q + 1'b1;

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      rd_mem_q[wr_ptr_q]   <= bus.wb_rd;
      data_mem_q[wr_ptr_q] <= bus.wb_data;
      seq_mem_q[wr_ptr_q]  <= seq_q;
    end
  end

  always_comb begin
    bus.trace_valid = !empty;
    bus.trace_rd    = empty ? '0 : rd_mem_q[rd_ptr_q];
    bus.trace_data  = empty ? '0 : data_mem_q[rd_ptr_q];
    bus.trace_seq   = empty ? '0 : seq_mem_q[rd_ptr_q];
    count_o         = count_q;
    full_o          = full;
    overflow_o      = overflow_q;
    drop_count_o    = drop_cnt_q;
  end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed bench for wb_trace_fifo: a default instance plus a 4-bit sequence instance for wrap.
module tb_wb_trace_fifo;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  wb_trace_fifo_if #(.SeqW(16)) bus ();
  wb_trace_fifo_if #(.SeqW(4))  bus4 ();

  logic [3:0]  count_a, count_b;
  logic        full_a, full_b, ovf_a, ovf_b;
  logic [15:0] drop_a, drop_b;

  wb_trace_fifo #(.Depth(8), .SeqW(16), .FilterX0(1'b1)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.slave),
    .count_o      (count_a),
    .full_o       (full_a),
    .overflow_o   (ovf_a),
    .drop_count_o (drop_a)
  );

  wb_trace_fifo #(.Depth(8), .SeqW(4), .FilterX0(1'b1)) u_dut4 (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus4.slave),
    .count_o      (count_b),
    .full_o       (full_b),
    .overflow_o   (ovf_b),
    .drop_count_o (drop_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic v, input logic [4:0] rd, input logic [63:0] data);
    bus.wb_valid = v;
    bus.wb_rd    = rd;
    bus.wb_data  = data;
  endtask

  initial begin
    reset = 1'b1;
    wb(1'b0, 5'd0, 64'd0);
    bus.trace_ready  = 1'b0;
    bus4.wb_valid    = 1'b0;
    bus4.wb_rd       = 5'd0;
    bus4.wb_data     = 64'd0;
    bus4.trace_ready = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;

    chk("rst_count", 64'(count_a), 64'd0);
    chk("rst_valid", 64'(bus.trace_valid), 64'd0);
    chk("rst_full", 64'(full_a), 64'd0);
    chk("rst_ovf", 64'(ovf_a), 64'd0);
    chk("rst_drop", 64'(drop_a), 64'd0);
    chk("rst_rd", 64'(bus.trace_rd), 64'd0);
    chk("rst_data", bus.trace_data, 64'd0);
    chk("rst_seq", 64'(bus.trace_seq), 64'd0);

    // Fill
    for (int i = 1; i <= 8; i++) begin
      wb(1'b1, 5'(i), 64'(i * 256));
      if (i == 1) chk("no_bypass", 64'(bus.trace_valid), 64'd0);
      cyc();
      if (i == 1) begin
        chk("lat_valid", 64'(bus.trace_valid), 64'd1);
        chk("lat_rd", 64'(bus.trace_rd), 64'd1);
      end
    end
    wb(1'b0, 5'd0, 64'd0);
    chk("fill_full", 64'(full_a), 64'd1);
    chk("fill_count", 64'(count_a), 64'd8);

    // Overflow: rd 9, 10 dropped
    wb(1'b1, 5'd9, 64'h900);
    cyc();
    wb(1'b1, 5'd10, 64'hA00);
    cyc();
    wb(1'b0, 5'd0, 64'd0);
    chk("ovf_flag", 64'(ovf_a), 64'd1);
    chk("ovf_drop", 64'(drop_a), 64'd2);
    chk("ovf_count", 64'(count_a), 64'd8);
    chk("ovf_head_rd", 64'(bus.trace_rd), 64'd1);

    // Drain
    bus.trace_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain_valid", 64'(bus.trace_valid), 64'd1);
      chk("drain_rd", 64'(bus.trace_rd), 64'(i));
      chk("drain_data", bus.trace_data, 64'(i * 256));
      chk("drain_seq", 64'(bus.trace_seq), 64'(i - 1));
      cyc();
    end
    chk("drained_valid", 64'(bus.trace_valid), 64'd0);
    chk("drained_count", 64'(count_a), 64'd0);
    chk("drained_ovf", 64'(ovf_a), 64'd1);
    // Empty with ready high: nothing moves
    cyc();
    chk("empty_pop_cnt", 64'(count_a), 64'd0);
    bus.trace_ready = 1'b0;

    // Seq after drops
    wb(1'b1, 5'd4, 64'h400);
    cyc();
    wb(1'b0, 5'd0, 64'd0);
    chk("post_drop_seq", 64'(bus.trace_seq), 64'd10);
    chk("post_drop_rd", 64'(bus.trace_rd), 64'd4);

    // Refill to full (rd 11..17, seq 11..17)
    for (int i = 11; i <= 17; i++) begin
      wb(1'b1, 5'(i), 64'(i));
      cyc();
    end
    chk("refill_full", 64'(full_a), 64'd1);

    // Full with simultaneous push and pop
    wb(1'b1, 5'd5, 64'hDEAD_BEEF);
    bus.trace_ready = 1'b1;
    cyc();
    wb(1'b0, 5'd0, 64'd0);
    bus.trace_ready = 1'b0;
    chk("fpp_count", 64'(count_a), 64'd8);
    chk("fpp_drop", 64'(drop_a), 64'd2);
    chk("fpp_head", 64'(bus.trace_rd), 64'd11);
    bus.trace_ready = 1'b1;
    for (int i = 11; i <= 17; i++) begin
      chk("fpp_drain_rd", 64'(bus.trace_rd), 64'(i));
      cyc();
    end
    chk("fpp_last_rd", 64'(bus.trace_rd), 64'd5);
    chk("fpp_last_data", bus.trace_data, 64'hDEAD_BEEF);
    chk("fpp_last_seq", 64'(bus.trace_seq), 64'd18);
    cyc();
    bus.trace_ready = 1'b0;
    chk("fpp_empty", 64'(bus.trace_valid), 64'd0);

    // x0 filter after reset
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wb(1'b1, 5'd0, 64'hBAD);
      cyc();
    end
    wb(1'b1, 5'd3, 64'h300);
    cyc();
    wb(1'b0, 5'd0, 64'd0);
    chk("x0_count", 64'(count_a), 64'd1);
    chk("x0_seq", 64'(bus.trace_seq), 64'd0);
    chk("x0_rd", 64'(bus.trace_rd), 64'd3);

    // Reach count 5 with overflow set
    for (int i = 1; i <= 8; i++) begin
      wb(1'b1, 5'(i), 64'(i));
      cyc();
    end
    wb(1'b0, 5'd0, 64'd0);
    bus.trace_ready = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    bus.trace_ready = 1'b0;
    chk("mid_count", 64'(count_a), 64'd5);
    chk("mid_ovf", 64'(ovf_a), 64'd1);
    chk("mid_drop", 64'(drop_a), 64'd1);

    // Reset concurrent with a push
    reset = 1'b1;
    wb(1'b1, 5'd9, 64'h999);
    cyc();
    reset = 1'b0;
    wb(1'b0, 5'd0, 64'd0);
    chk("rmid_count", 64'(count_a), 64'd0);
    chk("rmid_valid", 64'(bus.trace_valid), 64'd0);
    chk("rmid_ovf", 64'(ovf_a), 64'd0);
    chk("rmid_drop", 64'(drop_a), 64'd0);

    // Push into empty with ready high: stored, not popped the same edge
    wb(1'b1, 5'd6, 64'h600);
    bus.trace_ready = 1'b1;
    cyc();
    wb(1'b0, 5'd0, 64'd0);
    bus.trace_ready = 1'b0;
    chk("rpush_count", 64'(count_a), 64'd1);
    chk("rpush_rd", 64'(bus.trace_rd), 64'd6);
    chk("rpush_seq", 64'(bus.trace_seq), 64'd0);

    // Sequence wrap on the 4-bit instance
    for (int k = 0; k < 17; k++) begin
      bus4.wb_valid = 1'b1;
      bus4.wb_rd    = 5'(k + 1);
      cyc();
      bus4.wb_valid = 1'b0;
      chk("wrap_seq", 64'(bus4.trace_seq), 64'(k % 16));
      bus4.trace_ready = 1'b1;
      cyc();
      bus4.trace_ready = 1'b0;
    end
    chk("wrap_empty", 64'(count_b), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
